// File: rtl/register_file_pkg.sv
// Shared core constants used by the register file, reorder buffer and
// Dispatcher.
//   XLEN       : architectural data width
//   NUM_REGS   : number of architectural registers (x0..x31)
//   ROB_IDX_W  : reorder-buffer index width
//   REG_IDX_W  : register index width (always 5)
package register_file_pkg;
  localparam int XLEN      = 32;
  localparam int NUM_REGS  = 32;
  localparam int ROB_IDX_W = 3;
  localparam int REG_IDX_W = 5;
endpackage

// File: rtl/register_file.sv
// Architectural register file with rename status for the Tomasulo core.
// Each register carries a value, a busy bit and the RoB tag of its pending
// producer. Commits from the reorder buffer write values; the Dispatcher
// renames destinations. Two combinational read ports return either a ready
// value or the RoB tag to wait on, with a bypass for the commit in flight.
//   clk_in, rst_n_in      : clock, async active-low reset
//   rdy_in                : global enable (low freezes state, reads stay live)
//   RF_update_*           : commit write (en, reg, RoB index, data)
//   rename_*              : destination claim (en, reg, RoB index)
//   flush_signal          : misprediction flush, clears every busy bit
//   rs1_reg / rs2_reg     : read addresses
//   rsN_busy/value/tag    : read results
module register_file
  import register_file_pkg::*;
#(
  parameter int RoB_WIDTH = ROB_IDX_W,
  parameter int REG_COUNT = NUM_REGS
) (
  input  logic                 clk_in,
  input  logic                 rst_n_in,
  input  logic                 rdy_in,
  input  logic                 RF_update_en,
  input  logic [4:0]           RF_update_reg,
  input  logic [RoB_WIDTH-1:0] RF_update_index,
  input  logic [31:0]          RF_update_data,
  input  logic                 rename_en,
  input  logic [4:0]           rename_reg,
  input  logic [RoB_WIDTH-1:0] rename_index,
  input  logic                 flush_signal,
  input  logic [4:0]           rs1_reg,
  input  logic [4:0]           rs2_reg,
  output logic                 rs1_busy,
  output logic                 rs2_busy,
  output logic [31:0]          rs1_value,
  output logic [31:0]          rs2_value,
  output logic [RoB_WIDTH-1:0] rs1_tag,
  output logic [RoB_WIDTH-1:0] rs2_tag
);

  localparam int RD_W = 1 + RoB_WIDTH + XLEN;

  logic [REG_COUNT-1:0][XLEN-1:0]      value_q, value_d;
  logic [REG_COUNT-1:0]                busy_q,  busy_d;
  logic [REG_COUNT-1:0][RoB_WIDTH-1:0] tag_q,   tag_d;

  logic cmt_ok, ren_ok;
  assign cmt_ok = RF_update_en && (RF_update_reg != '0);
  assign ren_ok = rename_en && (rename_reg != '0);

  // Ordering below encodes the edge priority: commit clear first, rename
  // overrides it, flush overrides both for busy. Values are never touched
  // by flush or rename.
  always_comb begin
    value_d = value_q;
    busy_d  = busy_q;
    tag_d   = tag_q;
    if (rdy_in) begin
      if (cmt_ok) begin
        value_d[RF_update_reg] = RF_update_data;
        // Only the producer we are waiting on may release the register.
        if (tag_q[RF_update_reg] == RF_update_index)
          busy_d[RF_update_reg] = 1'b0;
      end
      if (flush_signal) begin
        busy_d = '0;
      end else if (ren_ok) begin
        busy_d[rename_reg] = 1'b1;
        tag_d[rename_reg]  = rename_index;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      value_q <= '0;
      busy_q  <= '0;
      tag_q   <= '0;
    end else begin
      value_q <= value_d;
      busy_q  <= busy_d;
      tag_q   <= tag_d;
    end
  end

  // Shared lookup for both ports: {busy, tag, value}. Reads see current
  // storage only (a same-cycle rename is invisible), except that a matching
  // commit in flight is forwarded as ready.
  function automatic logic [RD_W-1:0] rd_lookup(input logic [4:0] r);
    logic [RD_W-1:0] res;
    if (r == '0)
      res = '0;
    else if (RF_update_en && (RF_update_reg == r) && busy_q[r] &&
             (tag_q[r] == RF_update_index))
      res = {1'b0, tag_q[r], RF_update_data};
    else
      res = {busy_q[r], tag_q[r], value_q[r]};
    return res;
  endfunction

  assign {rs1_busy, rs1_tag, rs1_value} = rd_lookup(rs1_reg);
  assign {rs2_busy, rs2_tag, rs2_value} = rd_lookup(rs2_reg);

endmodule

// File: tb/tb_register_file.sv
module tb_register_file;
  import register_file_pkg::*;

  localparam int RW = ROB_IDX_W;

  logic          clk_in = 1'b0;
  logic          rst_n_in, rdy_in;
  logic          RF_update_en;
  logic [4:0]    RF_update_reg;
  logic [RW-1:0] RF_update_index;
  logic [31:0]   RF_update_data;
  logic          rename_en;
  logic [4:0]    rename_reg;
  logic [RW-1:0] rename_index;
  logic          flush_signal;
  logic [4:0]    rs1_reg, rs2_reg;
  logic          rs1_busy, rs2_busy;
  logic [31:0]   rs1_value, rs2_value;
  logic [RW-1:0] rs1_tag, rs2_tag;

  register_file dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in),
    .RF_update_en(RF_update_en), .RF_update_reg(RF_update_reg),
    .RF_update_index(RF_update_index), .RF_update_data(RF_update_data),
    .rename_en(rename_en), .rename_reg(rename_reg), .rename_index(rename_index),
    .flush_signal(flush_signal), .rs1_reg(rs1_reg), .rs2_reg(rs2_reg),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .rs1_value(rs1_value), .rs2_value(rs2_value),
    .rs1_tag(rs1_tag), .rs2_tag(rs2_tag)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic          port;
    logic          busy;
    logic [RW-1:0] tag;
    logic [31:0]   value;
    logic          chk_tag;
  } exp_t;

  exp_t  sb_q[$];
  string nm_q[$];
  int    checks   = 0;
  int    failures = 0;

  task automatic expect_rd(input logic port, input logic b, input logic [RW-1:0] t,
                           input logic [31:0] v, input logic ct, input string nm);
    exp_t e;
    e.port = port; e.busy = b; e.tag = t; e.value = v; e.chk_tag = ct;
    sb_q.push_back(e);
    nm_q.push_back(nm);
  endtask

  task automatic drain();
    exp_t          e;
    string         nm;
    logic [RW-1:0] ot, et;
    logic [35:0]   obs, exp;
    while (sb_q.size() > 0) begin
      e  = sb_q.pop_front();
      nm = nm_q.pop_front();
      et = e.chk_tag ? e.tag : '0;
      if (e.port == 1'b0) begin
        ot  = e.chk_tag ? rs1_tag : '0;
        obs = {rs1_busy, ot, rs1_value};
      end else begin
        ot  = e.chk_tag ? rs2_tag : '0;
        obs = {rs2_busy, ot, rs2_value};
      end
      exp = {e.busy, et, e.value};
      checks++;
      assert (obs === exp) else begin
        failures++;
        $error("FAIL %s observed={busy,tag,value}=%h expected=%h", nm, obs, exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    RF_update_en = 1'b0;
    rename_en    = 1'b0;
    flush_signal = 1'b0;
  endtask

  task automatic commit(input logic [4:0] r, input logic [RW-1:0] idx, input logic [31:0] d);
    RF_update_en = 1'b1; RF_update_reg = r; RF_update_index = idx; RF_update_data = d;
  endtask

  task automatic rename(input logic [4:0] r, input logic [RW-1:0] idx);
    rename_en = 1'b1; rename_reg = r; rename_index = idx;
  endtask

  initial begin
    rst_n_in = 1'b0; rdy_in = 1'b1;
    RF_update_reg = '0; RF_update_index = '0; RF_update_data = '0;
    rename_reg = '0; rename_index = '0;
    idle();
    rs1_reg = 5'd5; rs2_reg = 5'd0;
    #2;
    expect_rd(0, 0, 0, 32'h0, 1, "reset_x5");
    expect_rd(1, 0, 0, 32'h0, 1, "reset_x0");
    drain();
    tick();
    rst_n_in = 1'b1;

    // rename x5 tag 2: invisible this cycle, visible next
    rename(5'd5, 3'd2);
    #1; expect_rd(0, 0, 0, 32'h0, 0, "rename_same_cycle"); drain();
    tick(); idle();
    #1; expect_rd(0, 1, 3'd2, 32'h0, 1, "rename_next_cycle"); drain();

    // matching commit bypasses on both ports, then lands in storage
    rs2_reg = 5'd5;
    commit(5'd5, 3'd2, 32'h1234);
    #1;
    expect_rd(0, 0, 0, 32'h1234, 0, "bypass_rs1");
    expect_rd(1, 0, 0, 32'h1234, 0, "bypass_rs2");
    drain();
    tick(); idle();
    #1; expect_rd(0, 0, 0, 32'h1234, 0, "commit_stored"); drain();

    // older commit after re-rename keeps busy/tag, writes value
    rename(5'd5, 3'd2); tick();
    rename(5'd5, 3'd4); tick(); idle();
    commit(5'd5, 3'd2, 32'h7);
    #1; expect_rd(0, 1, 3'd4, 32'h1234, 1, "stale_commit_no_bypass"); drain();
    tick(); idle();
    #1; expect_rd(0, 1, 3'd4, 32'h7, 1, "stale_commit_keeps_busy"); drain();
    commit(5'd5, 3'd4, 32'h8); tick(); idle();
    #1; expect_rd(0, 0, 0, 32'h8, 0, "young_commit_clears"); drain();

    // commit + rename same register same cycle: rename wins busy/tag
    rs2_reg = 5'd3;
    commit(5'd3, 3'd1, 32'h9);
    rename(5'd3, 3'd5);
    #1; expect_rd(1, 0, 0, 32'h0, 0, "cmt_ren_same_cycle"); drain();
    tick(); idle();
    #1; expect_rd(1, 1, 3'd5, 32'h9, 1, "cmt_ren_rename_wins"); drain();

    // rename x1 while reading x1 shows the pre-rename status
    rs1_reg = 5'd1;
    rename(5'd1, 3'd0);
    #1; expect_rd(0, 0, 0, 32'h0, 0, "own_rd_pre_rename"); drain();
    tick();
    rename(5'd2, 3'd1);
    #1; expect_rd(0, 1, 3'd0, 32'h0, 1, "x1_busy"); drain();
    tick();
    rename(5'd3, 3'd2); tick(); idle();
    rs1_reg = 5'd2;
    #1;
    expect_rd(0, 1, 3'd1, 32'h0, 1, "x2_busy");
    expect_rd(1, 1, 3'd2, 32'h9, 1, "x3_rebusy");
    drain();

    // flush with commit x7 and a dropped rename of x4
    flush_signal = 1'b1;
    commit(5'd7, 3'd0, 32'hAA);
    rename(5'd4, 3'd3);
    tick(); idle();
    rs1_reg = 5'd1; rs2_reg = 5'd2;
    #1;
    expect_rd(0, 0, 0, 32'h0, 0, "flush_x1");
    expect_rd(1, 0, 0, 32'h0, 0, "flush_x2");
    drain();
    rs1_reg = 5'd3; rs2_reg = 5'd4;
    #1;
    expect_rd(0, 0, 0, 32'h9, 0, "flush_x3_keeps_value");
    expect_rd(1, 0, 0, 32'h0, 0, "flush_drops_rename_x4");
    drain();
    rs1_reg = 5'd7;
    #1; expect_rd(0, 0, 0, 32'hAA, 0, "flush_commit_x7"); drain();

    // multi-cycle flush keeps busy clear, rename during it dropped
    rename(5'd6, 3'd6); tick(); idle();
    flush_signal = 1'b1; tick();
    rename(5'd6, 3'd5); tick(); idle();
    rs1_reg = 5'd6;
    #1; expect_rd(0, 0, 0, 32'h0, 0, "long_flush_x6"); drain();

    // x0 is hardwired
    rs1_reg = 5'd0;
    commit(5'd0, 3'd0, 32'hFF);
    rename(5'd0, 3'd3);
    #1; expect_rd(0, 0, 0, 32'h0, 1, "x0_same_cycle"); drain();
    tick(); idle();
    #1; expect_rd(0, 0, 0, 32'h0, 1, "x0_after_write"); drain();

    // rdy_in low freezes commit, rename and flush
    rename(5'd6, 3'd6); tick(); idle();
    rdy_in = 1'b0;
    flush_signal = 1'b1;
    commit(5'd7, 3'd0, 32'h55);
    rename(5'd7, 3'd1);
    tick(); idle();
    rdy_in = 1'b1;
    rs1_reg = 5'd6; rs2_reg = 5'd7;
    #1;
    expect_rd(0, 1, 3'd6, 32'h0, 1, "rdy_low_no_flush");
    expect_rd(1, 0, 0, 32'hAA, 0, "rdy_low_no_commit");
    drain();

    // asynchronous reset clears outputs between edges
    #2;
    rst_n_in = 1'b0;
    #1;
    expect_rd(0, 0, 0, 32'h0, 1, "async_reset_x6");
    expect_rd(1, 0, 0, 32'h0, 1, "async_reset_x7");
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
